dcmi_dma_burst: RTL and testbench

DCMI_DMA_BURST -- requirements
Module: dcmi_dma_burst

---
 rtl/dcmi_pkg.sv | 16 +
 rtl/dcmi_sync_fifo.sv | 53 +++++
 rtl/dcmi_dma_burst.sv | 129 ++++++++++++
 tb/tb_dcmi_dma_burst.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcmi_pkg.sv
// Shared definitions for the DCMI-to-RAM burst writer.
// Holds the capture-mode encoding and the default parameter values
// used by dcmi_dma_burst and its buffer.
package dcmi_pkg;

    typedef enum logic {
        MODE_CIRC   = 1'b0,
        MODE_SINGLE = 1'b1
    } dma_mode_e;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 16;
    localparam int DEPTH_DEF = 8;
    localparam int OCW_DEF   = 8;

endpackage

// File: rtl/dcmi_sync_fifo.sv
// Single-clock FIFO that buffers camera words ahead of the RAM writer.
// Ports:
//   clk, rst        clock and synchronous active-high reset (pointers only)
//   flush           empties the buffer; a push in the same cycle becomes entry 0
//   push, wdata     write one word (caller guarantees room, or flush)
//   pop             drop the head word (caller guarantees non-empty)
//   rdata           current head word
//   level           number of entries held
module dcmi_sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PW:0]   wptr;
    logic [PW:0]   rptr;
    logic [PW-1:0] widx;
    logic [DW-1:0] mem [DEPTH];

    assign widx  = flush ? '0 : wptr[PW-1:0];
    assign rdata = mem[rptr[PW-1:0]];
    assign level = wptr - rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            rptr <= '0;
            wptr <= {{PW{1'b0}}, push};
        end else begin
            if (push) wptr <= wptr + (PW+1)'(1);
            if (pop)  rptr <= rptr + (PW+1)'(1);
        end
    end

    // Storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (push) mem[widx] <= wdata;
    end

endmodule

// File: rtl/dcmi_dma_burst.sv
// Camera-interface to RAM burst writer. Incoming words are buffered and
// written one per acknowledged request to a configurable address region,
// either wrapping (circular) or stopping at the region end (single-shot).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   block_en                  0 holds the block idle and cleared
//   mode                      0 circular, 1 single-shot (sampled at dcmi_start)
//   dcmi_start                frame start: flush, reload address, clear flags
//   dcmi_vld, dcmi_data       incoming word
//   dma_saddr, dma_len        region start and length (sampled at dcmi_start)
//   ram_wr_req/ack            write handshake; transfer when both high
//   ram_waddr, ram_wdata      write address and buffer head
//   buf_level                 entries buffered
//   ovfl_err, ovfl_cnt        sticky drop flag and saturating drop count
//   wrap_pulse                one cycle after a circular wrap
//   dma_done                  sticky single-shot completion
module dcmi_dma_burst
    import dcmi_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int OCW   = OCW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   block_en,
    input  logic                   mode,
    input  logic                   dcmi_start,
    input  logic                   dcmi_vld,
    input  logic [DW-1:0]          dcmi_data,
    input  logic [AW-1:0]          dma_saddr,
    input  logic [AW-1:0]          dma_len,
    output logic                   ram_wr_req,
    input  logic                   ram_wr_ack,
    output logic [AW-1:0]          ram_waddr,
    output logic [DW-1:0]          ram_wdata,
    output logic [$clog2(DEPTH):0] buf_level,
    output logic                   ovfl_err,
    output logic [OCW-1:0]         ovfl_cnt,
    output logic                   wrap_pulse,
    output logic                   dma_done
);

    localparam int LW = $clog2(DEPTH) + 1;

    function automatic logic [OCW-1:0] sat_inc(input logic [OCW-1:0] v);
        return (&v) ? v : v + OCW'(1);
    endfunction

    logic            clr;
    logic            full;
    logic            push;
    logic            drop;
    logic            xfer;
    logic [AW-1:0]   cfg_saddr;
    logic [AW-1:0]   cfg_len;
    dma_mode_e       cfg_mode;
    logic [AW-1:0]   end_addr;
    logic [DW-1:0]   head;

    assign clr  = rst | ~block_en;
    // Fullness is judged on the level before any same-cycle pop.
    assign full = (buf_level >= LW'(DEPTH));
    // A frame start flushes the buffer, so its word always fits.
    assign push = ~clr & dcmi_vld & (dcmi_start | ~full);
    assign drop = ~clr & ~dcmi_start & dcmi_vld & full;
    // Request depends only on registered state, never on ram_wr_ack.
    assign ram_wr_req = (buf_level != '0) & block_en & ~dma_done & (cfg_len != '0);
    assign xfer       = ram_wr_req & ram_wr_ack & ~dcmi_start;
    assign end_addr   = cfg_saddr + cfg_len - AW'(1);
    assign ram_wdata  = ram_wr_req ? head : '0;

    dcmi_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (clr),
        .flush (dcmi_start),
        .push  (push),
        .pop   (xfer),
        .wdata (dcmi_data),
        .rdata (head),
        .level (buf_level)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            cfg_saddr  <= '0;
            cfg_len    <= '0;
            cfg_mode   <= MODE_CIRC;
            ram_waddr  <= '0;
            ovfl_err   <= 1'b0;
            ovfl_cnt   <= '0;
            wrap_pulse <= 1'b0;
            dma_done   <= 1'b0;
        end else if (dcmi_start) begin
            cfg_saddr  <= dma_saddr;
            cfg_len    <= dma_len;
            cfg_mode   <= dma_mode_e'(mode);
            ram_waddr  <= dma_saddr;
            ovfl_err   <= 1'b0;
            ovfl_cnt   <= '0;
            wrap_pulse <= 1'b0;
            // An empty single-shot region is complete immediately.
            dma_done   <= (dma_mode_e'(mode) == MODE_SINGLE) && (dma_len == '0);
        end else begin
            wrap_pulse <= 1'b0;
            if (xfer) begin
                if (ram_waddr == end_addr) begin
                    if (cfg_mode == MODE_CIRC) begin
                        ram_waddr  <= cfg_saddr;
                        wrap_pulse <= 1'b1;
                    end else begin
                        dma_done <= 1'b1;
                    end
                end else begin
                    ram_waddr <= ram_waddr + AW'(1);
                end
            end
            if (drop) begin
                ovfl_err <= 1'b1;
                ovfl_cnt <= sat_inc(ovfl_cnt);
            end
        end
    end

endmodule

// File: tb/tb_dcmi_dma_burst.sv
module tb_dcmi_dma_burst;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 8;
    localparam int OCW   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, block_en, mode, dcmi_start, dcmi_vld, ram_wr_ack;
    logic [DW-1:0] dcmi_data;
    logic [AW-1:0] dma_saddr, dma_len;

    logic          ram_wr_req, ovfl_err, wrap_pulse, dma_done;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [3:0]    buf_level;
    logic [OCW-1:0] ovfl_cnt;

    logic          r2_req, r2_err, r2_wrap, r2_done;
    logic [AW-1:0] r2_waddr;
    logic [DW-1:0] r2_wdata;
    logic [3:0]    r2_level;
    logic [1:0]    r2_cnt;

    dcmi_dma_burst #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .OCW(OCW)) dut (
        .clk(clk), .rst(rst), .block_en(block_en), .mode(mode),
        .dcmi_start(dcmi_start), .dcmi_vld(dcmi_vld), .dcmi_data(dcmi_data),
        .dma_saddr(dma_saddr), .dma_len(dma_len),
        .ram_wr_req(ram_wr_req), .ram_wr_ack(ram_wr_ack),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .buf_level(buf_level),
        .ovfl_err(ovfl_err), .ovfl_cnt(ovfl_cnt), .wrap_pulse(wrap_pulse),
        .dma_done(dma_done)
    );

    dcmi_dma_burst #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .OCW(2)) dut2 (
        .clk(clk), .rst(rst), .block_en(block_en), .mode(mode),
        .dcmi_start(dcmi_start), .dcmi_vld(dcmi_vld), .dcmi_data(dcmi_data),
        .dma_saddr(dma_saddr), .dma_len(dma_len),
        .ram_wr_req(r2_req), .ram_wr_ack(ram_wr_ack),
        .ram_waddr(r2_waddr), .ram_wdata(r2_wdata), .buf_level(r2_level),
        .ovfl_err(r2_err), .ovfl_cnt(r2_cnt), .wrap_pulse(r2_wrap),
        .dma_done(r2_done)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural reference: a queue of buffered words plus region state.
    logic [DW-1:0]  mq[$];
    logic [AW-1:0]  wlog[$];
    logic [AW-1:0]  m_waddr = '0, m_saddr = '0, m_len = '0;
    logic           m_mode = 1'b0, m_err = 1'b0, m_wrap = 1'b0, m_done = 1'b0;
    logic [OCW-1:0] m_cnt = '0;
    int             dut_wraps = 0;

    function automatic logic m_req();
        return (mq.size() != 0) && block_en && !m_done && (m_len != 0);
    endfunction

    always @(posedge clk) begin : model
        logic          xfer;
        int            sz;
        logic [AW-1:0] eaddr;
        xfer = m_req() && ram_wr_ack && !dcmi_start;
        sz   = mq.size();
        if (rst || !block_en) begin
            mq.delete();
            m_waddr = '0; m_saddr = '0; m_len = '0; m_mode = 1'b0;
            m_err = 1'b0; m_cnt = '0; m_wrap = 1'b0; m_done = 1'b0;
        end else if (dcmi_start) begin
            mq.delete();
            m_saddr = dma_saddr; m_len = dma_len; m_mode = mode;
            m_waddr = dma_saddr;
            m_err = 1'b0; m_cnt = '0; m_wrap = 1'b0;
            m_done = mode && (dma_len == 0);
            if (dcmi_vld) mq.push_back(dcmi_data);
        end else begin
            m_wrap = 1'b0;
            if (xfer) begin
                wlog.push_back(m_waddr);
                void'(mq.pop_front());
                eaddr = m_saddr + m_len - 16'd1;
                if (m_waddr == eaddr) begin
                    if (!m_mode) begin m_waddr = m_saddr; m_wrap = 1'b1; end
                    else m_done = 1'b1;
                end else begin
                    m_waddr = m_waddr + 16'd1;
                end
            end
            if (dcmi_vld) begin
                if (sz < DEPTH) mq.push_back(dcmi_data);
                else begin
                    m_err = 1'b1;
                    if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin : compare
        logic exp_req;
        #1;
        exp_req = m_req();
        chk("ram_wr_req", ram_wr_req, exp_req);
        chk("ram_waddr", ram_waddr, m_waddr);
        if (exp_req) chk("ram_wdata", ram_wdata, mq[0]);
        chk("buf_level", buf_level, mq.size());
        chk("ovfl_err", ovfl_err, m_err);
        chk("ovfl_cnt", ovfl_cnt, m_cnt);
        chk("wrap_pulse", wrap_pulse, m_wrap);
        chk("dma_done", dma_done, m_done);
        if (wrap_pulse) dut_wraps++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic frame(input logic md, input logic [AW-1:0] sa, input logic [AW-1:0] ln);
        mode = md; dma_saddr = sa; dma_len = ln; dcmi_start = 1'b1;
        step();
        dcmi_start = 1'b0;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            dcmi_vld = 1'b1; dcmi_data = $urandom;
            step();
        end
        dcmi_vld = 1'b0;
    endtask

    logic [AW-1:0] e26 [6];
    logic [AW-1:0] e29 [5];

    initial begin
        e26 = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0100, 16'h0101};
        e29 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE};
        rst = 1'b1; block_en = 1'b1; mode = 1'b0; dcmi_start = 1'b0;
        dcmi_vld = 1'b0; dcmi_data = '0; dma_saddr = '0; dma_len = '0; ram_wr_ack = 1'b0;
        repeat (3) step();
        chk("reset_req", ram_wr_req, 1'b0);
        chk("reset_level", buf_level, 4'd0);
        rst = 1'b0;
        step();

        // Circular region of 4 words at 0x100, six words
        ram_wr_ack = 1'b1;
        frame(1'b0, 16'h0100, 16'd4);
        wlog.delete(); dut_wraps = 0;
        push_words(6);
        repeat (10) step();
        chk("circ_nwrites", wlog.size(), 6);
        for (int i = 0; i < 6; i++) if (i < wlog.size()) chk("circ_addr", wlog[i], e26[i]);
        chk("circ_wraps", dut_wraps, 1);

        // Single-shot region of 3 words, five words
        frame(1'b1, 16'h0010, 16'd3);
        wlog.delete();
        push_words(5);
        repeat (10) step();
        chk("single_nwrites", wlog.size(), 3);
        for (int i = 0; i < 3; i++) if (i < wlog.size()) chk("single_addr", wlog[i], 16'h0010 + 16'(i));
        chk("single_model_done", m_done, 1'b1);
        chk("single_model_level", mq.size(), 2);
        chk("single_done", dma_done, 1'b1);
        chk("single_level", buf_level, 4'd2);
        chk("single_req", ram_wr_req, 1'b0);

        // Overflow with ack held low
        ram_wr_ack = 1'b0;
        frame(1'b0, 16'h0000, 16'd4);
        push_words(11);
        chk("ovf_model_level", mq.size(), 8);
        chk("ovf_model_cnt", m_cnt, 3);
        chk("ovf_model_err", m_err, 1'b1);
        chk("ovf_level", buf_level, 4'd8);
        chk("ovf_cnt", ovfl_cnt, 8'd3);
        chk("ovf_err", ovfl_err, 1'b1);
        push_words(2);
        chk("ovf_model_cnt5", m_cnt, 5);
        chk("ovf_cnt5", ovfl_cnt, 8'd5);
        chk("ovf_sat_ocw2", r2_cnt, 2'd3);

        // Wrap across the top of the address space
        ram_wr_ack = 1'b1;
        frame(1'b0, 16'hFFFE, 16'd4);
        wlog.delete();
        push_words(5);
        repeat (10) step();
        chk("topwrap_nwrites", wlog.size(), 5);
        for (int i = 0; i < 5; i++) if (i < wlog.size()) chk("topwrap_addr", wlog[i], e29[i]);

        // Restart while words are buffered, then reset mid-burst
        ram_wr_ack = 1'b0;
        frame(1'b0, 16'h0020, 16'd6);
        push_words(5);
        chk("restart_pre_level", buf_level, 4'd5);
        mode = 1'b1; dma_saddr = 16'h0040; dma_len = 16'd8;
        dcmi_start = 1'b1; dcmi_vld = 1'b1; dcmi_data = 32'hCAFE_0001;
        step();
        dcmi_start = 1'b0; dcmi_vld = 1'b0;
        chk("restart_level", buf_level, 4'd1);
        chk("restart_waddr", ram_waddr, 16'h0040);
        chk("restart_wdata", ram_wdata, 32'hCAFE_0001);
        chk("restart_err", ovfl_err, 1'b0);
        chk("restart_cnt", ovfl_cnt, 8'd0);
        chk("restart_done", dma_done, 1'b0);
        ram_wr_ack = 1'b1;
        push_words(3);
        rst = 1'b1;
        step();
        chk("midrst_req", ram_wr_req, 1'b0);
        chk("midrst_waddr", ram_waddr, 16'h0000);
        chk("midrst_wdata", ram_wdata, 32'h0);
        chk("midrst_level", buf_level, 4'd0);
        chk("midrst_err", ovfl_err, 1'b0);
        chk("midrst_cnt", ovfl_cnt, 8'd0);
        chk("midrst_wrap", wrap_pulse, 1'b0);
        chk("midrst_done", dma_done, 1'b0);
        rst = 1'b0;
        step();
        chk("postrst_req", ram_wr_req, 1'b0);

        // Randomised traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            int vp;
            vp = (c / 500) % 4;
            rst        = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 249) == 0) block_en = 1'b0;
            else if ($urandom_range(0, 3) == 0) block_en = 1'b1;
            dcmi_start = ($urandom_range(0, 59) == 0);
            mode       = $urandom_range(0, 1);
            dma_saddr  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15));
            dma_len    = 16'($urandom_range(0, 12));
            dcmi_vld   = ($urandom_range(0, 3) <= vp);
            dcmi_data  = $urandom;
            ram_wr_ack = ($urandom_range(0, 3) >= vp);
            step();
        end
        rst = 1'b0; block_en = 1'b1; dcmi_start = 1'b0; dcmi_vld = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
